crypto_ctrl: RTL
================

CRYPTO_CTRL -- requirements
Module: crypto_ctrl

Interface
REQ-001 Parameter MEMORY_WIDTH, default 8, meaning log2 of the memory window size in bytes; MEMORY_BYTES = 1 << MEMORY_WIDTH.
REQ-002 Parameter TIMEOUT_CYCLES, default 65535, meaning the maximum number of WAIT cycles before the operation is aborted.
REQ-003 Port clk_usb, input, 1, the single clock (buffered USB clock); all logic is on its rising edge.
REQ-004 Port reset, input, 1, synchronous, active-high reset.
REQ-005 Port memory_input, input, MEMORY_BYTES*8, the host-written window: bytes 0-15 plaintext, bytes 16-31 key, byte 32 control (bit0 = GO).
REQ-006 Port memory_output, output, MEMORY_BYTES*8, the host-read window: bytes 0-15 ciphertext, bytes 16-19 cycle count (little-endian), byte 20 status; all other bytes 0.
REQ-007 Port crypt_textin, output, 128, the plaintext snapshot to the core; byte 0 maps to bits [127:120].
REQ-008 Port crypt_key, output, 128, the key snapshot to the core; byte 16 maps to bits [127:120].
REQ-009 Port crypt_start, output, 1, a one-cycle start pulse to the core.
REQ-010 Port crypt_busy, input, 1, high while the core is computing.
REQ-011 Port crypt_done, input, 1, a one-cycle pulse when crypt_textout is valid.
REQ-012 Port crypt_textout, input, 128, the core result; bits [127:120] map to output byte 0.
REQ-013 Port trigger, output, 1, the capture trigger for the scope.

Function
REQ-014 The control byte is written by the host asynchronously to clk_usb, so GO SHALL pass through a 2-flop synchronizer followed by a rising-edge detector; only a synchronized 0->1 transition is a start request.
REQ-015 States SHALL be IDLE, LOAD, START, WAIT, CAPTURE.
REQ-016 IDLE: a start request moves the FSM to LOAD; a request seen in any other state SHALL be ignored and not queued.
REQ-017 LOAD (1 cycle): register bytes 0-31 into crypt_textin/crypt_key; clear the done and timeout status bits; clear the cycle counter; go to START.
REQ-018 START (1 cycle): crypt_start=1; trigger rises this cycle; set status busy; go to WAIT.
REQ-019 WAIT: the cycle counter increments by 1 per cycle and saturates at 0xFFFFFFFF; crypt_done=1 moves the FSM to CAPTURE.
REQ-020 WAIT timeout: if the counter reaches TIMEOUT_CYCLES without crypt_done, set status timeout, clear busy, drop trigger, and return to IDLE; the ciphertext bytes are unchanged.
REQ-021 CAPTURE (1 cycle): latch crypt_textout into ciphertext bytes 0-15; clear busy; set done; drop trigger; return to IDLE.
REQ-022 Start-to-done latency: crypt_start is asserted 3 cycles after the GO edge reaches the synchronizer input (2 synchronizer + 1 LOAD); memory_output updates 1 cycle after crypt_done.
REQ-023 Status byte 20: bit0 busy, bit1 done, bit2 timeout, bit3 = crypt_busy (live), bits 7:4 = 0.
REQ-024 crypt_done while in IDLE, LOAD or START SHALL be ignored.
REQ-025 crypt_textin and crypt_key SHALL hold stable from LOAD until the next LOAD.
REQ-026 memory_output SHALL be registered; there is no combinational path from any input to memory_output.
REQ-027 Host writes to bytes 0-31 while busy SHALL NOT affect the running operation.

Reset
REQ-028 Reset SHALL be synchronous and active-high; while it is asserted: FSM=IDLE, synchronizer and edge-detect flops=0, crypt_start=0, trigger=0, crypt_textin=0, crypt_key=0, counter=0, all memory_output bytes=0.
REQ-029 Reset asserted mid-operation SHALL abort immediately; a crypt_done that arrives after reset is released SHALL be ignored.
REQ-030 A GO bit already high when reset is released SHALL NOT start an operation until it goes low and then high again.

Verification
REQ-031 Nominal: pt=00112233..FF, key=000102..0F, GO 0->1, core model gives done 10 cycles after start with textout=69C4E0D8..C55A -> crypt_start 3 cycles after GO; bytes 0-15=69C4..5A; count=10; status=0x02.
REQ-032 Timeout: TIMEOUT_CYCLES=20, core never asserts done -> status=0x04 after 20 WAIT cycles; trigger low; ciphertext bytes unchanged; FSM in IDLE.
REQ-033 Re-trigger during busy: GO toggles 1->0->1 while in WAIT -> no second crypt_start; the first result is captured normally.
REQ-034 Reset mid-WAIT: assert reset on cycle 5 of WAIT, then the core pulses done -> all outputs 0; ciphertext stays 0; status=0x00.
REQ-035 GO high through reset: GO=1 before and after reset is released -> no crypt_start; after GO goes 0 then 1, a normal operation runs.
REQ-036 Plaintext write during busy: write byte 0=0xAA while in WAIT -> crypt_textin[127:120] keeps its LOAD value until the next start.

Source files
------------

// File: rtl/crypto_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : crypto_ctrl
// Brief    : Host memory-window sequencer for a 128-bit block-cipher core.
// Revision : 1.0 - initial release
// ============================================================================
module crypto_ctrl #(
    parameter int MEMORY_WIDTH   = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                              clk_usb,
    input  logic                              reset,
    input  logic [(1 << MEMORY_WIDTH)*8-1:0]  memory_input,
    output logic [(1 << MEMORY_WIDTH)*8-1:0]  memory_output,
    output logic [127:0]                      crypt_textin,
    output logic [127:0]                      crypt_key,
    output logic                              crypt_start,
    input  logic                              crypt_busy,
    input  logic                              crypt_done,
    input  logic [127:0]                      crypt_textout,
    output logic                              trigger
);

    localparam int          MEMORY_BYTES = 1 << MEMORY_WIDTH;
    localparam int          GO_BIT       = 32 * 8;
    localparam logic [31:0] TIMEOUT_C    = 32'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        START   = 3'd2,
        WAIT    = 3'd3,
        CAPTURE = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic           go_meta_q, go_sync_q, go_prev_q;
    logic [1:0]     fill_q;
    logic           armed_q;
    logic           start_req_w;
    logic [127:0]   textin_q, key_q, cipher_q;
    logic [31:0]    cnt_q, cnt_inc_w;
    logic           timeout_hit_w;
    logic           start_q, trigger_q;
    logic           busy_q, done_q, tout_q, cbusy_q;
    logic           unused_mem_w;

    assign unused_mem_w = ^{memory_input[MEMORY_BYTES*8-1:33*8], memory_input[GO_BIT+7:GO_BIT+1]};

    // GO synchronizer. fill_q marks when go_sync_q holds a real sample, so a GO
    // that was already high at reset release cannot look like a fresh edge.
    always_ff @(posedge clk_usb) begin
        if (reset) begin
            go_meta_q <= 1'b0;
            go_sync_q <= 1'b0;
            go_prev_q <= 1'b0;
            fill_q    <= 2'b00;
            armed_q   <= 1'b0;
        end else begin
            go_meta_q <= memory_input[GO_BIT];
            go_sync_q <= go_meta_q;
            go_prev_q <= go_sync_q;
            fill_q    <= {fill_q[0], 1'b1};
            armed_q   <= armed_q | (fill_q[1] & ~go_sync_q);
        end
    end

    assign start_req_w   = go_sync_q & ~go_prev_q & armed_q;
    assign cnt_inc_w     = (&cnt_q) ? cnt_q : cnt_q + 32'd1;
    assign timeout_hit_w = (state_q == WAIT) && !crypt_done && (cnt_inc_w >= TIMEOUT_C);

    always_ff @(posedge clk_usb) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_req_w) state_d = LOAD;
            LOAD:    state_d = START;
            START:   state_d = WAIT;
            WAIT: begin
                if (crypt_done) begin
                    state_d = CAPTURE;
                end else if (timeout_hit_w) begin
                    state_d = IDLE;
                end
            end
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Result and status are taken on the edge that leaves WAIT with done, so the
    // host window updates one cycle after crypt_done; CAPTURE is then a settle cycle.
    always_ff @(posedge clk_usb) begin
        if (reset) begin
            textin_q  <= '0;
            key_q     <= '0;
            cipher_q  <= '0;
            cnt_q     <= '0;
            start_q   <= 1'b0;
            trigger_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tout_q    <= 1'b0;
            cbusy_q   <= 1'b0;
        end else begin
            start_q <= (state_q == LOAD);
            cbusy_q <= crypt_busy;
            case (state_q)
                LOAD: begin
                    for (int i = 0; i < 16; i++) begin
                        textin_q[127-8*i -: 8] <= memory_input[8*i +: 8];
                        key_q[127-8*i -: 8]    <= memory_input[8*(16+i) +: 8];
                    end
                    done_q    <= 1'b0;
                    tout_q    <= 1'b0;
                    cnt_q     <= '0;
                    trigger_q <= 1'b1;
                    busy_q    <= 1'b1;
                end
                WAIT: begin
                    cnt_q <= cnt_inc_w;
                    if (crypt_done) begin
                        cipher_q  <= crypt_textout;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        trigger_q <= 1'b0;
                    end else if (timeout_hit_w) begin
                        tout_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        trigger_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        memory_output = '0;
        for (int i = 0; i < 16; i++) begin
            memory_output[8*i +: 8] = cipher_q[127-8*i -: 8];
        end
        memory_output[16*8 +: 32] = cnt_q;
        memory_output[20*8 +: 8]  = {4'b0000, cbusy_q, tout_q, done_q, busy_q};
    end

    assign crypt_textin = textin_q;
    assign crypt_key    = key_q;
    assign crypt_start  = start_q;
    assign trigger      = trigger_q;

endmodule
`default_nettype wire
